uart_txrx: RTL and testbench

// - 8N1 UART core for the v65C02 computer: one transmitter and one receiver sharing a 16x baud strobe.
// - Sits between the CPU bus register file and the serial pins; the bus logic writes TX bytes and collects RX bytes.
// - Frame: start bit (0), 8 data bits LSB first, stop bit (1). No parity, no FIFO.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx.sv | 116 +++++++++++
 rtl/uart_tx.sv | 91 +++++++++
 rtl/uart_txrx.sv | 37 +++
 tb/tb_uart_txrx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART core: frame geometry and FSM states.
`timescale 1ns/1ps
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // Tick counter values: last tick of a bit period and the mid-bit point
    // used to qualify a start bit.
    localparam logic [3:0] TICK_LAST = 4'd15;
    localparam logic [3:0] TICK_MID  = 4'd7;

    // Index of the final data bit.
    localparam logic [2:0] BIT_LAST  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the line, qualifies the start bit at mid-bit,
// samples each data bit at its centre and checks the stop bit.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       brg_stb_i,
    input  logic       rx_din_i,
    output logic [7:0] rx_dout_o,
    output logic       rx_done_stb_o
);

    logic        r_sync1;
    logic        r_sync2;
    logic        w_rx;
    uart_state_e r_state;
    logic [3:0]  r_tick;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_dout;
    logic        r_done;
    logic        r_ferr;

    // Two-stage synchronizer; idles at the line's mark level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_din_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    // Receive FSM; a framing error parks in STOP until the line is high again.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_tick  <= 4'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_dout  <= 8'h00;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ferr <= 1'b0;
                    if (!w_rx) begin
                        r_tick  <= 4'd0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (brg_stb_i) begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == TICK_MID) begin
                            if (!w_rx) begin
                                r_tick  <= 4'd0;
                                r_bit   <= 3'd0;
                                r_state <= DATA;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                DATA: begin
                    if (brg_stb_i) begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == TICK_LAST) begin
                            r_shift <= {w_rx, r_shift[7:1]};
                            if (r_bit == BIT_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (r_ferr) begin
                        if (w_rx) begin
                            r_ferr  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (brg_stb_i) begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == TICK_LAST) begin
                            if (w_rx) begin
                                r_dout  <= r_shift;
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_ferr <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ferr  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_dout_o     = r_dout;
    assign rx_done_stb_o = r_done;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: sends start bit, 8 data bits LSB first, stop bit.
// Every bit is held for 16 baud strobes.
`timescale 1ns/1ps
module uart_tx
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       brg_stb_i,
    input  logic       tx_we_i,
    input  logic [7:0] tx_din_i,
    output logic       tx_dout_o,
    output logic       tx_busy_o
);

    uart_state_e r_state;
    logic [3:0]  r_tick;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_busy;

    // Transmit FSM; line level and busy flag are registered with the state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_tick  <= 4'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tx_we_i) begin
                        r_shift <= tx_din_i;
                        r_tick  <= 4'd0;
                        r_bit   <= 3'd0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (brg_stb_i) begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == TICK_LAST) begin
                            r_tx    <= r_shift[0];
                            r_bit   <= 3'd0;
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (brg_stb_i) begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == TICK_LAST) begin
                            if (r_bit == BIT_LAST) begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end else begin
                                // Next bit comes from position 1 before the shift lands.
                                r_shift <= {1'b0, r_shift[7:1]};
                                r_tx    <= r_shift[1];
                                r_bit   <= r_bit + 3'd1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (brg_stb_i) begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == TICK_LAST) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_dout_o = r_tx;
    assign tx_busy_o = r_busy;

endmodule

// File: rtl/uart_txrx.sv
// 8N1 UART core: independent transmitter and receiver sharing the 16x baud strobe.
`timescale 1ns/1ps
module uart_txrx
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       brg_stb_i,
    input  logic       tx_we_i,
    input  logic [7:0] tx_din_i,
    output logic       tx_dout_o,
    output logic       tx_busy_o,
    input  logic       rx_din_i,
    output logic [7:0] rx_dout_o,
    output logic       rx_done_stb_o
);

    uart_tx u_tx (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .brg_stb_i (brg_stb_i),
        .tx_we_i   (tx_we_i),
        .tx_din_i  (tx_din_i),
        .tx_dout_o (tx_dout_o),
        .tx_busy_o (tx_busy_o)
    );

    uart_rx u_rx (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .brg_stb_i     (brg_stb_i),
        .rx_din_i      (rx_din_i),
        .rx_dout_o     (rx_dout_o),
        .rx_done_stb_o (rx_done_stb_o)
    );

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: TX looped back to RX, with an override
// so the bench can drive the RX line directly for error cases.
`timescale 1ns/1ps
module tb_uart_txrx;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       brg_stb_i = 1'b0;
    logic       tx_we_i = 1'b0;
    logic [7:0] tx_din_i = 8'h00;
    logic       tx_dout_o;
    logic       tx_busy_o;
    logic       rx_din_i;
    logic [7:0] rx_dout_o;
    logic       rx_done_stb_o;

    logic       force_en = 1'b0;
    logic       force_val = 1'b1;
    logic [1:0] stb_cnt = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int strobe_cnt = 0;
    int strobe_cycle = 0;
    logic [7:0] rx_q[$];

    localparam int BIT_CLKS = 64;

    assign rx_din_i = force_en ? force_val : tx_dout_o;

    uart_txrx dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .brg_stb_i     (brg_stb_i),
        .tx_we_i       (tx_we_i),
        .tx_din_i      (tx_din_i),
        .tx_dout_o     (tx_dout_o),
        .tx_busy_o     (tx_busy_o),
        .rx_din_i      (rx_din_i),
        .rx_dout_o     (rx_dout_o),
        .rx_done_stb_o (rx_done_stb_o)
    );

    always #5 clk_i = ~clk_i;

    // Baud strobe: one clock in every four.
    always @(posedge clk_i) begin
        stb_cnt   <= stb_cnt + 2'd1;
        brg_stb_i <= (stb_cnt == 2'd3);
    end

    // Monitor: count cycles, record every received byte and when it arrived.
    always @(negedge clk_i) begin
        cycle <= cycle + 1;
        if (rx_done_stb_o) begin
            strobe_cnt   <= strobe_cnt + 1;
            strobe_cycle <= cycle;
            rx_q.push_back(rx_dout_o);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        @(negedge clk_i);
        rx_q.delete();
        strobe_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk_i);
        tx_we_i  = 1'b1;
        tx_din_i = b;
        @(negedge clk_i);
        tx_we_i  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (tx_busy_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_busy_fall"}, int'(tx_busy_o), 0);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Drive one frame directly onto the RX line.
    task automatic bitbang(input logic [7:0] b, input logic stop);
        force_en  = 1'b1;
        force_val = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            force_val = b[i];
            wait_clks(BIT_CLKS);
        end
        force_val = stop;
        wait_clks(BIT_CLKS);
        force_val = 1'b1;
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_dout;
        int         exp_strobes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int send_cycle;
        vecs[0] = '{8'h75, 8'h75, 1};
        vecs[1] = '{8'h00, 8'h00, 1};
        vecs[2] = '{8'hFF, 8'hFF, 1};
        vecs[3] = '{8'hA5, 8'hA5, 1};
        vecs[4] = '{8'h01, 8'h01, 1};
        vecs[5] = '{8'h80, 8'h80, 1};

        // Reset state
        wait_clks(3);
        check("rst_tx_dout", int'(tx_dout_o), 1);
        check("rst_tx_busy", int'(tx_busy_o), 0);
        check("rst_rx_dout", int'(rx_dout_o), 8'h00);
        check("rst_rx_done", int'(rx_done_stb_o), 0);
        rst_n_i = 1'b1;
        wait_clks(5);

        // Loopback table (T1 is the first entry)
        for (int v = 0; v < 6; v++) begin
            clr_mon();
            send_cycle = cycle;
            send(vecs[v].din);
            check($sformatf("v%0d_busy_next", v), int'(tx_busy_o), 1);
            check($sformatf("v%0d_line_start", v), int'(tx_dout_o), 0);
            wait_idle($sformatf("v%0d", v));
            wait_clks(20);
            check($sformatf("v%0d_strobes", v), strobe_cnt, vecs[v].exp_strobes);
            check($sformatf("v%0d_rx_dout", v), int'(rx_dout_o), int'(vecs[v].exp_dout));
            if (v == 0) begin
                check("t1_latency_ok",
                      int'((strobe_cycle - send_cycle) >= 580 && (strobe_cycle - send_cycle) <= 660), 1);
            end
        end

        // T2: back-to-back frames launched on busy fall
        clr_mon();
        send(8'h00);
        wait_idle("t2a");
        send(8'hFF);
        wait_idle("t2b");
        send(8'hA5);
        wait_idle("t2c");
        wait_clks(20);
        check("t2_strobes", strobe_cnt, 3);
        if (rx_q.size() == 3) begin
            check("t2_byte0", int'(rx_q[0]), 8'h00);
            check("t2_byte1", int'(rx_q[1]), 8'hFF);
            check("t2_byte2", int'(rx_q[2]), 8'hA5);
        end

        // T3: write while busy is ignored
        clr_mon();
        send(8'h75);
        wait_clks(200);
        send(8'h3C);
        check("t3_busy_mid", int'(tx_busy_o), 1);
        wait_idle("t3");
        wait_clks(20);
        check("t3_strobes", strobe_cnt, 1);
        check("t3_rx_dout", int'(rx_dout_o), 8'h75);
        wait_clks(200);
        check("t3_no_restart", int'(tx_busy_o), 0);

        // T4: false start (low for 4 ticks)
        clr_mon();
        force_en  = 1'b1;
        force_val = 1'b0;
        wait_clks(16);
        force_val = 1'b1;
        wait_clks(300);
        check("t4_strobes", strobe_cnt, 0);
        check("t4_rx_dout", int'(rx_dout_o), 8'h75);

        // T5: framing error, then a good frame
        clr_mon();
        bitbang(8'h55, 1'b0);
        wait_clks(100);
        check("t5_ferr_strobes", strobe_cnt, 0);
        check("t5_ferr_rx_dout", int'(rx_dout_o), 8'h75);
        force_en = 1'b0;
        wait_clks(20);
        send(8'h12);
        wait_idle("t5");
        wait_clks(20);
        check("t5_strobes", strobe_cnt, 1);
        check("t5_rx_dout", int'(rx_dout_o), 8'h12);

        // T6: reset mid-frame
        clr_mon();
        send(8'h55);
        wait_clks(200);
        rst_n_i = 1'b0;
        #1;
        check("t6_rst_tx_dout", int'(tx_dout_o), 1);
        check("t6_rst_tx_busy", int'(tx_busy_o), 0);
        check("t6_rst_rx_dout", int'(rx_dout_o), 8'h00);
        check("t6_rst_rx_done", int'(rx_done_stb_o), 0);
        wait_clks(3);
        rst_n_i = 1'b1;
        wait_clks(5);
        clr_mon();
        send(8'h81);
        wait_idle("t6");
        wait_clks(20);
        check("t6_strobes", strobe_cnt, 1);
        check("t6_rx_dout", int'(rx_dout_o), 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
